// File: rtl/zone_release.sv
// -----------------------------------------------------------------------------
// zone_release
// Departure-side companion of the zone allocator. The operator selects a zone
// with sw1..sw4, keys a digit 1-9 and confirms. The amount is checked against
// the allocator's live occupancy for that zone. A valid amount is sent as one
// release request (zone + amount) over a valid/ready handshake.
//
// Optional feature macro: PARTIAL_RELEASE_EN
//   defined   : an over-sized request is clamped to the zone occupancy
//               (error only when the zone is empty)
//   undefined : any amount above the occupancy is an error
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous reset, active-low
//   sw1_i..sw4_i in   zone select, priority sw1 > sw2 > sw3 > sw4
//   key_edge_i   in   [9:1] digit pulses, [10] CONFIRM, [11] CANCEL
//   occ1_i..occ4_i in current occupied count per zone
//   rel_ready_i  in   allocator accepts the request this cycle
//   rel_valid_o  out  release request pending
//   rel_zone_o   out  0..3 = zone 1..4
//   rel_amt_o    out  slots to release
//   pend_amt_o   out  digit currently entered (0 when none)
//   busy_o       out  controller not idle
//   err_o        out  amount rejected, waiting for operator
// -----------------------------------------------------------------------------
module zone_release #(
    parameter int CAPACITY    = 15,
    parameter int TIMEOUT_CYC = 200000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sw1_i,
    input  logic        sw2_i,
    input  logic        sw3_i,
    input  logic        sw4_i,
    input  logic [15:0] key_edge_i,
    input  logic [3:0]  occ1_i,
    input  logic [3:0]  occ2_i,
    input  logic [3:0]  occ3_i,
    input  logic [3:0]  occ4_i,
    input  logic        rel_ready_i,
    output logic        rel_valid_o,
    output logic [1:0]  rel_zone_o,
    output logic [3:0]  rel_amt_o,
    output logic [3:0]  pend_amt_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam int          TW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  CAP_L   = 4'(CAPACITY);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_REQ   = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    // Fixed-priority zone encode: lowest-numbered active switch wins.
    function automatic logic [1:0] zone_encode(input logic s1, input logic s2,
                                               input logic s3, input logic s4);
        logic [1:0] z;
        if (s1) begin
            z = 2'd0;
        end else if (s2) begin
            z = 2'd1;
        end else if (s3) begin
            z = 2'd2;
        end else if (s4) begin
            z = 2'd3;
        end else begin
            z = 2'd0;
        end
        return z;
    endfunction

    // Binary value of a one-hot digit vector (bit 0 = digit 1).
    function automatic logic [3:0] digit_encode(input logic [8:0] k);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 9; i++) begin
            d = k[i] ? 4'(i + 1) : d;
        end
        return d;
    endfunction

    state_t        state_q, state_d;
    logic [1:0]    zone_q, zone_d;
    logic [3:0]    pend_q, pend_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [1:0]    rel_zone_q, rel_zone_d;
    logic [3:0]    rel_amt_q, rel_amt_d;
    logic          rel_valid_q, rel_valid_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    logic          cancel_s;
    logic          confirm_s;
    logic          digit_s;
    logic [3:0]    digit_val_s;
    logic          sw_any_s;
    logic [3:0]    occ_raw_s;
    logic [3:0]    occ_sel_s;
    logic          unused_keys_s;

    // Key decode. CANCEL masks CONFIRM, and either masks a digit, so at most
    // one event is acted on per cycle. Multi-hot digit vectors are discarded.
    always_comb begin
        cancel_s    = key_edge_i[11];
        confirm_s   = key_edge_i[10] & ~key_edge_i[11];
        digit_s     = $onehot(key_edge_i[9:1]) & ~key_edge_i[10] & ~key_edge_i[11];
        digit_val_s = digit_encode(key_edge_i[9:1]);
        sw_any_s    = sw1_i | sw2_i | sw3_i | sw4_i;
    end

    assign unused_keys_s = &{1'b0, key_edge_i[0], key_edge_i[15:12]};

    // Occupancy of the latched zone, saturated at the zone capacity so a
    // corrupted count can never authorise more than a full zone.
    always_comb begin
        case (zone_q)
            2'd0:    occ_raw_s = occ1_i;
            2'd1:    occ_raw_s = occ2_i;
            2'd2:    occ_raw_s = occ3_i;
            2'd3:    occ_raw_s = occ4_i;
            default: occ_raw_s = 4'd0;
        endcase
        if (occ_raw_s > CAP_L) begin
            occ_sel_s = CAP_L;
        end else begin
            occ_sel_s = occ_raw_s;
        end
    end

    // Next-state and datapath decisions for the release controller.
    always_comb begin
        state_d    = state_q;
        zone_d     = zone_q;
        pend_d     = pend_q;
        timer_d    = timer_q;
        rel_zone_d = rel_zone_q;
        rel_amt_d  = rel_amt_q;

        case (state_q)
            ST_IDLE: begin
                if (digit_s && sw_any_s) begin
                    state_d = ST_ENTRY;
                    zone_d  = zone_encode(sw1_i, sw2_i, sw3_i, sw4_i);
                    pend_d  = digit_val_s;
                    timer_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_ENTRY: begin
                if (cancel_s) begin
                    state_d = ST_IDLE;
                    pend_d  = 4'd0;
                    timer_d = '0;
                end else if (confirm_s) begin
                    timer_d = '0;
                    if (pend_q <= occ_sel_s) begin
                        state_d    = ST_REQ;
                        rel_zone_d = zone_q;
                        rel_amt_d  = pend_q;
`ifdef PARTIAL_RELEASE_EN
                    end else if (occ_sel_s != 4'd0) begin
                        // Release what is actually parked instead of refusing.
                        state_d    = ST_REQ;
                        rel_zone_d = zone_q;
                        rel_amt_d  = occ_sel_s;
`endif
                    end else begin
                        state_d = ST_ERR;
                    end
                end else if (digit_s) begin
                    pend_d  = digit_val_s;
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    pend_d  = 4'd0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_REQ: begin
                // Keys are deliberately ignored: the request is committed.
                if (rel_valid_q && rel_ready_i) begin
                    state_d    = ST_IDLE;
                    pend_d     = 4'd0;
                    rel_zone_d = 2'd0;
                    rel_amt_d  = 4'd0;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_ERR: begin
                if (cancel_s) begin
                    state_d = ST_IDLE;
                    pend_d  = 4'd0;
                    timer_d = '0;
                end else if (digit_s) begin
                    // Retry on the same (frozen) zone.
                    state_d = ST_ENTRY;
                    pend_d  = digit_val_s;
                    timer_d = '0;
                end else if (timer_q == TO_LAST) begin
                    state_d = ST_IDLE;
                    pend_d  = 4'd0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: begin
                state_d    = ST_IDLE;
                zone_d     = 2'd0;
                pend_d     = 4'd0;
                timer_d    = '0;
                rel_zone_d = 2'd0;
                rel_amt_d  = 4'd0;
            end
        endcase

        // Status flags are derived from the next state so they register
        // together with it and never lag the state by a cycle.
        rel_valid_d = (state_d == ST_REQ);
        busy_d      = (state_d != ST_IDLE);
        err_d       = (state_d == ST_ERR);
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            zone_q      <= 2'd0;
            pend_q      <= 4'd0;
            timer_q     <= '0;
            rel_zone_q  <= 2'd0;
            rel_amt_q   <= 4'd0;
            rel_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            zone_q      <= zone_d;
            pend_q      <= pend_d;
            timer_q     <= timer_d;
            rel_zone_q  <= rel_zone_d;
            rel_amt_q   <= rel_amt_d;
            rel_valid_q <= rel_valid_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign rel_valid_o = rel_valid_q;
    assign rel_zone_o  = rel_zone_q;
    assign rel_amt_o   = rel_amt_q;
    assign pend_amt_o  = pend_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;

endmodule
